// File: rtl/sigmag_stat_acc.sv
// sigmag_stat_acc: per-line sig/mag window counters with snapshot bank, lock/overrun, sequence number and read port.
// Define SIGMAG_STAT_SYNC_EN to pass enable/lock/start/ovr_clr through 2-flop synchronisers.
module sigmag_stat_acc #(
  parameter int LINES = 4,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [LINES-1:0]   sig_i,
  input  logic [LINES-1:0]   mag_i,
  input  logic               enable_i,
  input  logic               mode_i,
  input  logic               start_i,
  input  logic [WIN_W-1:0]   win_len_i,
  input  logic               lock_i,
  input  logic               ovr_clr_i,
  input  logic               rd_req_i,
  input  logic [7:0]         rd_addr_i,
  output logic               rd_ack_o,
  output logic [2*CNT_W-1:0] rd_data_o,
  output logic               rd_err_o,
  output logic               valid_o,
  output logic               done_o,
  output logic [7:0]         seq_o,
  output logic               ovr_o
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  logic enable_s, lock_s, start_lvl, start_p, ovr_clr_p;
`ifdef SIGMAG_STAT_SYNC_EN
  logic [1:0] en_sq, lk_sq, st_sq, oc_sq;
  logic st_dq, oc_dq;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      en_sq <= '0;
      lk_sq <= '0;
      st_sq <= '0;
      oc_sq <= '0;
      st_dq <= 1'b0;
      oc_dq <= 1'b0;
    end else begin
      en_sq <= {en_sq[0], enable_i};
      lk_sq <= {lk_sq[0], lock_i};
      st_sq <= {st_sq[0], start_i};
      oc_sq <= {oc_sq[0], ovr_clr_i};
      st_dq <= st_sq[1];
      oc_dq <= oc_sq[1];
    end
  end
  assign enable_s  = en_sq[1];
  assign lock_s    = lk_sq[1];
  assign start_lvl = st_sq[1];
  assign start_p   = st_sq[1] & ~st_dq;
  assign ovr_clr_p = oc_sq[1] & ~oc_dq;
`else
  assign enable_s  = enable_i;
  assign lock_s    = lock_i;
  assign start_lvl = start_i;
  assign start_p   = start_i;
  assign ovr_clr_p = ovr_clr_i;
`endif
  state_t state_q, state_d;
  logic [WIN_W-1:0] len_q, len_d, win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] sig_acc_q [LINES];
  logic [CNT_W-1:0] mag_acc_q [LINES];
  logic [CNT_W-1:0] sig_snap_q [LINES];
  logic [CNT_W-1:0] mag_snap_q [LINES];
  logic [CNT_W-1:0] sig_sum [LINES];
  logic [CNT_W-1:0] mag_sum [LINES];
  logic [2*CNT_W-1:0] rd_sel, rd_data_q;
  logic [7:0] seq_q;
  logic counting, win_end, snap, clr, in_range;
  logic valid_q, done_q, ovr_q, rd_ack_q, rd_err_q;
  // sum includes the current cycle's sample so the final sample lands in the snapshot
  always_comb begin
    for (int i = 0; i < LINES; i++) begin
      sig_sum[i] = (sig_acc_q[i] == MAX) ? MAX : sig_acc_q[i] + CNT_W'(sig_i[i]);
      mag_sum[i] = (mag_acc_q[i] == MAX) ? MAX : mag_acc_q[i] + CNT_W'(mag_i[i]);
    end
  end
  assign counting = (state_q == RUN) && enable_s;
  assign win_end  = counting && (win_cnt_q == len_q - WIN_W'(1));
  assign snap     = win_end && !lock_s;
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    win_cnt_d = win_cnt_q;
    clr       = 1'b0;
    unique case (state_q)
      IDLE: if (enable_s && (!mode_i || start_p) && win_len_i != '0) begin
        state_d   = RUN;
        len_d     = win_len_i;
        win_cnt_d = '0;
        clr       = 1'b1;
      end
      RUN: if (!enable_s) begin
        state_d = IDLE;
        clr     = 1'b1;
      end else if (win_end) begin
        len_d     = win_len_i;
        win_cnt_d = '0;
        clr       = 1'b1;
        state_d   = mode_i ? HOLD : (win_len_i == '0 ? IDLE : RUN);
      end else begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
      end
      HOLD: state_d = start_lvl ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign in_range = {24'b0, rd_addr_i} < LINES;
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < LINES; i++)
      if (rd_addr_i == 8'(i)) rd_sel = {sig_snap_q[i], mag_snap_q[i]};
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      win_cnt_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      seq_q     <= '0;
      ovr_q     <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_data_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        sig_acc_q[i]  <= '0;
        mag_acc_q[i]  <= '0;
        sig_snap_q[i] <= '0;
        mag_snap_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      win_cnt_q <= win_cnt_d;
      done_q    <= snap;
      valid_q   <= valid_q | snap;
      seq_q     <= snap ? seq_q + 8'd1 : seq_q;
      ovr_q     <= (win_end && lock_s) | (ovr_q & ~ovr_clr_p);
      rd_ack_q  <= rd_req_i;
      rd_err_q  <= rd_req_i & ~in_range;
      rd_data_q <= (rd_req_i && in_range) ? rd_sel : '0;
      for (int i = 0; i < LINES; i++) begin
        sig_acc_q[i] <= clr ? '0 : counting ? sig_sum[i] : sig_acc_q[i];
        mag_acc_q[i] <= clr ? '0 : counting ? mag_sum[i] : mag_acc_q[i];
        if (snap) begin
          sig_snap_q[i] <= sig_sum[i];
          mag_snap_q[i] <= mag_sum[i];
        end
      end
    end
  end
  assign rd_ack_o  = rd_ack_q;
  assign rd_err_o  = rd_err_q;
  assign rd_data_o = rd_data_q;
  assign valid_o   = valid_q;
  assign done_o    = done_q;
  assign seq_o     = seq_q;
  assign ovr_o     = ovr_q;
endmodule

// File: tb/tb_sigmag_stat_acc.sv
// tb_sigmag_stat_acc: scoreboard bench for sigmag_stat_acc (LINES=4, CNT_W=8).
module tb_sigmag_stat_acc;
  localparam int LINES = 4, CNT_W = 8, WIN_W = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] sig = '0;
  logic [2:0] mag_hi = '0;
  logic mag_t = 1'b0, tog = 1'b0, mag_fix = 1'b0;
  logic enable = 1'b0, mode = 1'b0, start = 1'b0, lock = 1'b0, ovr_clr = 1'b0, rd_req = 1'b0;
  logic [15:0] win_len = 16'd10;
  logic [7:0] rd_addr = '0;
  logic rd_ack, rd_err, valid, done, ovr;
  logic [15:0] rd_data;
  logic [7:0] seq;
  int cyc = 0, done_cnt = 0, n_cmp = 0, n_err = 0;
  typedef struct {logic [7:0] seq; int cyc;} dn_t;
  typedef struct {logic [15:0] data; logic err; int addr;} rd_t;
  dn_t dq[$];
  rd_t rq[$];
  dn_t de;
  rd_t re;

  sigmag_stat_acc #(.LINES(LINES), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk_i(clk), .reset_i(reset), .sig_i(sig), .mag_i({mag_hi, mag_t}),
    .enable_i(enable), .mode_i(mode), .start_i(start), .win_len_i(win_len),
    .lock_i(lock), .ovr_clr_i(ovr_clr), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .rd_ack_o(rd_ack), .rd_data_o(rd_data), .rd_err_o(rd_err),
    .valid_o(valid), .done_o(done), .seq_o(seq), .ovr_o(ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // line 0 magnitude either toggles every sample or holds mag_fix
  always @(posedge clk) begin
    #1;
    mag_t = tog ? ~mag_t : mag_fix;
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      n_cmp++;
      if (dq.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: seq=%0d cyc=%0d, no snapshot expected", seq, cyc);
      end else begin
        de = dq.pop_front();
        if (seq !== de.seq || valid !== 1'b1 || cyc != de.cyc) begin
          n_err++;
          $display("FAIL done_seq: seq=%0d valid=%b cyc=%0d, required seq=%0d valid=1 cyc=%0d",
                   seq, valid, cyc, de.seq, de.cyc);
        end
      end
    end
    if (rd_ack) begin
      n_cmp++;
      if (rq.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: data=%h err=%b, no read pending", rd_data, rd_err);
      end else begin
        re = rq.pop_front();
        if (rd_data !== re.data || rd_err !== re.err) begin
          n_err++;
          $display("FAIL rd_addr%0d: data=%h err=%b, required data=%h err=%b",
                   re.addr, rd_data, rd_err, re.data, re.err);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic rd(input int a, input logic [15:0] d, input logic e);
    rq.push_back('{d, e, a});
    rd_req = 1'b1;
    rd_addr = 8'(a);
    step(1);
    rd_req = 1'b0;
  endtask

  task automatic wait_done(input int tgt, input int budget);
    int i = 0;
    while (done_cnt < tgt && i < budget) begin
      step(1);
      i++;
    end
    n_cmp++;
    if (done_cnt < tgt) begin
      n_err++;
      $display("FAIL wait_done: got %0d snapshots, required %0d", done_cnt, tgt);
    end
  endtask

  initial begin
    int c, d;
    step(3);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_seq", 32'(seq), 0);
    chk("rst_ovr", 32'(ovr), 0);
    chk("rst_rd_ack", 32'(rd_ack), 0);
    reset = 1'b0;
    step(1);
    // continuous, win_len=10: line0 sig=10, mag=5 each window
    sig = 4'b0001; tog = 1'b1; mode = 1'b0; win_len = 16'd10;
    c = cyc;
    dq.push_back('{8'd1, c + 11});
    dq.push_back('{8'd2, c + 21});
    dq.push_back('{8'd3, c + 31});
    enable = 1'b1;
    wait_done(3, 60);
    // lock across the next boundary with sig cleared so a wrong update is visible
    d = cyc;
    dq.push_back('{8'd4, d + 20});
    lock = 1'b1; sig = 4'b0000;
    rd(0, 16'h0A05, 1'b0);
    rd(1, 16'h0000, 1'b0);
    rd(4, 16'h0000, 1'b1);
    rd(255, 16'h0000, 1'b1);
    step(6);
    sig = 4'b0001;
    chk("ovr_set", 32'(ovr), 1);
    chk("lock_seq", 32'(seq), 3);
    rd(0, 16'h0A05, 1'b0);
    step(1);
    lock = 1'b0;
    wait_done(4, 30);
    chk("ovr_sticky", 32'(ovr), 1);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    chk("ovr_clr", 32'(ovr), 0);
    rd(0, 16'h0A05, 1'b0);
    // abort mid-window: no snapshot, bank kept
    enable = 1'b0;
    step(20);
    rd(0, 16'h0A05, 1'b0);
    // one-shot, win_len=3, all ones; start held high to keep HOLD
    mode = 1'b1; win_len = 16'd3; sig = 4'hF; tog = 1'b0; mag_fix = 1'b1; mag_hi = 3'b111;
    enable = 1'b1;
    step(3);
    c = cyc;
    dq.push_back('{8'd5, c + 4});
    start = 1'b1;
    wait_done(5, 10);
    step(8);
    start = 1'b0;
    step(10);
    for (int i = 0; i < 4; i++) rd(i, 16'h0303, 1'b0);
    // saturation with 8-bit counters over a 300-sample window
    win_len = 16'd300; sig = 4'b0001;
    c = cyc;
    dq.push_back('{8'd6, c + 301});
    mode = 1'b0;
    wait_done(6, 400);
    enable = 1'b0;
    rd(0, 16'hFFFF, 1'b0);
    rd(1, 16'h00FF, 1'b0);
    rd(3, 16'h00FF, 1'b0);
    // reset mid-window, then a full-length first window
    mode = 1'b0; win_len = 16'd10; sig = 4'b0001; mag_hi = 3'b000; tog = 1'b1;
    enable = 1'b1;
    step(5);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_seq", 32'(seq), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_rd_data", 32'(rd_data), 0);
    step(1);
    c = cyc;
    dq.push_back('{8'd1, c + 11});
    reset = 1'b0;
    wait_done(7, 30);
    rd(0, 16'h0A05, 1'b0);
    enable = 1'b0;
    step(5);
    chk("done_queue_empty", dq.size(), 0);
    chk("rd_queue_empty", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sigmag_stat_acc.md
Name: sigmag_stat_acc

Overview:
- Parametrised multi-line sign/magnitude statistics accumulator for the ADC front-end.
- Per line, counts the samples with sig=1 and with mag=1 over a programmable window, then snapshots the counts into a readout bank.
- Adds continuous and one-shot modes, a lock with overrun detection, a window sequence number, and a req/ack read port with addresses checked against LINES.

Parameters:
- LINES, 4, number of analysed sig/mag line pairs (1..256).
- CNT_W, 16, width of each per-line counter and snapshot (8..32).
- WIN_W, 16, width of the window-length input.

Ports:
- clk  in  1  sample clock.
- reset  in  1  asynchronous, active-high reset.
- sig  in  LINES  sign bits, one per line.
- mag  in  LINES  magnitude bits, one per line.
- enable  in  1  level; run acquisition.
- mode  in  1  0 = continuous, 1 = one-shot.
- start  in  1  pulse; arms one window in one-shot mode.
- win_len  in  WIN_W  window length in samples.
- lock  in  1  level; freezes the snapshot bank.
- ovr_clr  in  1  pulse; clears the overrun flag.
- rd_req  in  1  pulse; read request.
- rd_addr  in  8  line index to read.
- rd_ack  out  1  one-cycle read acknowledge.
- rd_data  out  2*CNT_W  read data, {sig_snap, mag_snap}.
- rd_err  out  1  set with rd_ack when rd_addr >= LINES.
- valid  out  1  sticky; at least one snapshot has been taken.
- done  out  1  one-cycle pulse on each snapshot update.
- seq  out  8  snapshot sequence number, wraps 255 -> 0.
- ovr  out  1  sticky overrun flag.

Behaviour:
- Reset: state IDLE; all counters, snapshots, rd_data, rd_ack, rd_err, valid, done, seq and ovr are 0.
- States: IDLE, RUN, HOLD.
- IDLE -> RUN:
  - mode=0: on enable=1.
  - mode=1: on enable=1 and start=1.
  - On entry, latch win_len into len_q, clear win_cnt and all accumulators. The first counted sample is the cycle after entry.
- IDLE with win_len=0: stays in IDLE, no snapshot.
- RUN: each cycle, per line, add sig[i] to sig_acc[i] and mag[i] to mag_acc[i]; increment win_cnt.
- Counters saturate at 2^CNT_W-1. No wrap.
- End of window (win_cnt == len_q-1):
  - The final sample is included in the snapshot.
  - The snapshot bank loads on the next edge, so it holds exactly len_q samples.
  - Accumulators restart from 0 with no lost sample.
  - win_cnt returns to 0; len_q re-latches win_len.
- At the snapshot edge, if lock=0: update the bank, pulse done, seq+1, set valid.
- At the snapshot edge, if lock=1: bank unchanged, no done, seq unchanged, ovr <= 1. The window's data is discarded.
- After end of window, mode=0: stay in RUN. mode=1: go to HOLD.
- HOLD -> IDLE when start=0.
- enable=0 in RUN: abort at once to IDLE, clear accumulators, no snapshot, bank kept.
- mode and win_len changes take effect only at window boundaries or IDLE entry.
- ovr_clr clears ovr. If set and clear coincide, set wins.
- Read port:
  - rd_req sampled every cycle; rd_ack is high the next cycle.
  - rd_data = {sig_snap[rd_addr], mag_snap[rd_addr]} from the registered bank.
  - rd_addr >= LINES: rd_data = 0, rd_err = 1.
  - A read in the same cycle as a bank update returns the old contents.
  - Back-to-back rd_req is allowed; one ack per request.
- rd_ack and rd_err return to 0 when there is no request.

Optional Feature:
- Macro SIGMAG_STAT_SYNC_EN.
- Defined: lock, enable, start and ovr_clr pass through 2-flop synchronisers; level for enable/lock, edge-detect for start/ovr_clr. rd_addr is captured with rd_req. Control latency +2 cycles.
- Undefined: all controls are assumed synchronous to clk and used directly.

Test Plan:
- LINES=4, mode=0, win_len=10, sig[0]=1 constant, mag[0] toggling:
  - Each window -> line 0 reads sig=10, mag=5; done every 10 cycles; seq increments.
- Overrun: lock=1 across one boundary.
  - Bank unchanged, ovr=1, no done.
  - lock=0 at the next boundary -> update happens.
  - ovr_clr -> ovr=0.
- One-shot: mode=1, start pulse, win_len=3, all bits 1.
  - One done only; counts 3/3.
  - FSM in HOLD until start=0, then IDLE; no further updates.
- Saturation: CNT_W=8, win_len=300, sig=1 -> sig_snap=255.
- Abort and read checks:
  - enable=0 mid-window -> no done, bank retains the prior window.
  - rd_addr=4 with LINES=4 -> rd_ack=1, rd_err=1, rd_data=0.
- Reset: assert reset mid-window -> all outputs 0 immediately; restart produces a full-length first window.
